hazard_control_unit: RTL and testbench

- Consumer side of the ID/EX stage register.
- Reads decoded source addresses in ID, plus the control/address fields that ID/EX, EX/MEM and MEM/WB present downstream.
- Decides stall, bubble-insert, flush and operand-forwarding selects for the 5-stage MIPS pipeline.
- Adds a sequential FSM for multi-cycle EX ops (multiply) and multi-cycle branch flush, plus saturating stall/flush statistics counters.

---
 rtl/hazard_control_unit_if.sv | 45 ++++
 rtl/hazard_control_unit.sv | 130 +++++++++++++
 tb/tb_hazard_control_unit.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_control_unit_if.sv
// hazard_control_unit_if: pipeline-register fields consumed by the hazard unit and the
// stall/flush/forward controls it returns.
interface hazard_control_unit_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs_addr;
    logic [4:0]       id_rt_addr;
    logic             id_uses_rt;
    logic [4:0]       ex_rs_addr;
    logic [4:0]       ex_rt_addr;
    logic [4:0]       ex_dest_addr;
    logic             ex_reg_write;
    logic             ex_mem_read;
    logic             ex_mul_start;
    logic             ex_branch_taken;
    logic [4:0]       mem_dest_addr;
    logic             mem_reg_write;
    logic [4:0]       wb_dest_addr;
    logic             wb_reg_write;
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             idex_hold;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             busy;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_rs_addr, id_rt_addr, id_uses_rt, ex_rs_addr, ex_rt_addr, ex_dest_addr,
               ex_reg_write, ex_mem_read, ex_mul_start, ex_branch_taken,
               mem_dest_addr, mem_reg_write, wb_dest_addr, wb_reg_write,
        input  pc_write, ifid_write, ifid_flush, idex_bubble, idex_hold, fwd_a, fwd_b,
               busy, stall_cnt, flush_cnt
    );
    modport slave (
        input  id_rs_addr, id_rt_addr, id_uses_rt, ex_rs_addr, ex_rt_addr, ex_dest_addr,
               ex_reg_write, ex_mem_read, ex_mul_start, ex_branch_taken,
               mem_dest_addr, mem_reg_write, wb_dest_addr, wb_reg_write,
        output pc_write, ifid_write, ifid_flush, idex_bubble, idex_hold, fwd_a, fwd_b,
               busy, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_control_unit.sv
// hazard_control_unit: stall/bubble/flush/forward control for a 5-stage MIPS pipeline,
// with multi-cycle multiply and branch-flush sequencing and saturating statistics.
module hazard_control_unit #(
    parameter int MUL_LATENCY  = 4,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input logic                 clk,
    input logic                 rst,
    hazard_control_unit_if.slave hz
);
    typedef enum logic [1:0] {RUN, MUL_BUSY, FLUSH} state_t;
    localparam int CMAX = (MUL_LATENCY > FLUSH_CYCLES) ? MUL_LATENCY : FLUSH_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    logic             load_use, pc_write, ifid_write, ifid_flush, idex_bubble, idex_hold, busy;
    logic [1:0]       fwd_a, fwd_b;

    function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic [4:0] m_dst,
                                           input logic m_we, input logic [4:0] w_dst,
                                           input logic w_we);
        return (m_we && m_dst != 5'd0 && m_dst == src) ? 2'b10 :
               (w_we && w_dst != 5'd0 && w_dst == src) ? 2'b01 : 2'b00;
    endfunction

    assign load_use = hz.ex_mem_read && hz.ex_dest_addr != 5'd0 &&
                      (hz.ex_dest_addr == hz.id_rs_addr ||
                       (hz.id_uses_rt && hz.ex_dest_addr == hz.id_rt_addr));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (hz.ex_branch_taken) begin
                    if (FLUSH_CYCLES > 1) begin
                        state_d = FLUSH;
                        cnt_d   = CW'(FLUSH_CYCLES - 2);
                    end
                end else if (hz.ex_mul_start) begin
                    state_d = MUL_BUSY;
                    cnt_d   = CW'(MUL_LATENCY - 2);
                end
            end
            default: begin
                if (cnt_q == '0) state_d = RUN;
                else cnt_d = cnt_q - CW'(1);
            end
        endcase
    end

    // Reset forces the quiet control set regardless of what the pipeline presents.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        idex_hold   = 1'b0;
        busy        = 1'b0;
        fwd_a       = 2'b00;
        fwd_b       = 2'b00;
        if (rst) begin
            fwd_a = fwd_sel(hz.ex_rs_addr, hz.mem_dest_addr, hz.mem_reg_write,
                            hz.wb_dest_addr, hz.wb_reg_write);
            fwd_b = fwd_sel(hz.ex_rt_addr, hz.mem_dest_addr, hz.mem_reg_write,
                            hz.wb_dest_addr, hz.wb_reg_write);
            case (state_q)
                RUN: begin
                    if (hz.ex_branch_taken) begin
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                    end else if (hz.ex_mul_start) begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        idex_hold  = 1'b1;
                    end else if (load_use) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                    end
                end
                MUL_BUSY: begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    idex_hold  = 1'b1;
                    busy       = 1'b1;
                end
                default: begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    busy        = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = (!pc_write && !(&stall_cnt_q)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
        flush_cnt_d = (state_q == RUN && hz.ex_branch_taken && !(&flush_cnt_q)) ?
                      flush_cnt_q + CNT_W'(1) : flush_cnt_q;
    end

    assign hz.pc_write    = pc_write;
    assign hz.ifid_write  = ifid_write;
    assign hz.ifid_flush  = ifid_flush;
    assign hz.idex_bubble = idex_bubble;
    assign hz.idex_hold   = idex_hold;
    assign hz.busy        = busy;
    assign hz.fwd_a       = fwd_a;
    assign hz.fwd_b       = fwd_b;
    assign hz.stall_cnt   = stall_cnt_q;
    assign hz.flush_cnt   = flush_cnt_q;
endmodule

// File: tb/tb_hazard_control_unit.sv
// tb_hazard_control_unit: scenario tasks push expected control vectors into a scoreboard
// queue as stimulus is applied and pop them when the cycle's outputs settle.
module tb_hazard_control_unit;
    localparam int CW = 4;
    // {pc_write, ifid_write, ifid_flush, idex_bubble, idex_hold, busy, fwd_a, fwd_b}
    localparam logic [9:0] IDLE = 10'b11_0000_0000;
    localparam logic [9:0] LU   = 10'b00_0100_0000;
    localparam logic [9:0] MS   = 10'b00_0010_0000;
    localparam logic [9:0] MB   = 10'b00_0011_0000;
    localparam logic [9:0] BR   = 10'b11_1100_0000;
    localparam logic [9:0] FL   = 10'b11_1101_0000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    int         checks = 0;
    int         errors = 0;
    int         exp_stall = 0;
    int         exp_flush = 0;
    logic [9:0] sb[$];
    logic [9:0] e;
    logic [9:0] ctl;

    logic [4:0] lu_dst [4] = '{5'd8, 5'd0, 5'd8, 5'd8};
    logic [4:0] lu_rs  [4] = '{5'd8, 5'd0, 5'd3, 5'd3};
    logic [4:0] lu_rt  [4] = '{5'd0, 5'd0, 5'd8, 5'd8};
    logic       lu_urt [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic       lu_stl [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    logic [4:0] f_rs [6] = '{5'd5, 5'd5, 5'd0, 5'd3, 5'd9, 5'd5};
    logic [4:0] f_rt [6] = '{5'd0, 5'd5, 5'd0, 5'd7, 5'd9, 5'd5};
    logic [4:0] f_md [6] = '{5'd5, 5'd5, 5'd0, 5'd7, 5'd4, 5'd5};
    logic       f_mw [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [4:0] f_wd [6] = '{5'd5, 5'd5, 5'd0, 5'd3, 5'd6, 5'd5};
    logic       f_ww [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [1:0] f_a  [6] = '{2'b10, 2'b01, 2'b00, 2'b01, 2'b00, 2'b10};
    logic [1:0] f_b  [6] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b10};

    hazard_control_unit_if #(.CNT_W(CW)) hz ();

    hazard_control_unit #(.MUL_LATENCY(4), .FLUSH_CYCLES(3), .CNT_W(CW)) dut (
        .clk(clk),
        .rst(rst),
        .hz (hz.slave)
    );

    always #5 clk = ~clk;

    assign ctl = {hz.pc_write, hz.ifid_write, hz.ifid_flush, hz.idex_bubble, hz.idex_hold,
                  hz.busy, hz.fwd_a, hz.fwd_b};

    task automatic idle();
        hz.id_rs_addr = 0; hz.id_rt_addr = 0; hz.id_uses_rt = 0;
        hz.ex_rs_addr = 0; hz.ex_rt_addr = 0; hz.ex_dest_addr = 0;
        hz.ex_reg_write = 0; hz.ex_mem_read = 0; hz.ex_mul_start = 0; hz.ex_branch_taken = 0;
        hz.mem_dest_addr = 0; hz.mem_reg_write = 0; hz.wb_dest_addr = 0; hz.wb_reg_write = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        idle();
        @(negedge clk);
        rst = 1'b1;
        exp_stall = 0;
        exp_flush = 0;
    endtask

    task automatic test_reset();
        idle();
        hz.ex_mem_read = 1; hz.ex_dest_addr = 8; hz.id_rs_addr = 8; hz.ex_mul_start = 1;
        hz.ex_rs_addr = 5; hz.mem_dest_addr = 5; hz.mem_reg_write = 1;
        #2;
        checks += 2;
        if (ctl !== IDLE) begin errors++; $display("FAIL reset_ctl got %b exp %b", ctl, IDLE); end
        if (hz.stall_cnt !== 4'd0 || hz.flush_cnt !== 4'd0) begin
            errors++;
            $display("FAIL reset_cnt got %0d/%0d exp 0/0", hz.stall_cnt, hz.flush_cnt);
        end
        idle();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            hz.ex_mul_start = (i == 0);
            sb.push_back(i == 0 ? MS : MB);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (ctl !== e) begin errors++; $display("FAIL reset_mul[%0d] got %b exp %b", i, ctl, e); end
        end
        rst = 1'b0;
        exp_stall = 0;
        exp_flush = 0;
        #1;
        checks += 2;
        if (ctl !== IDLE) begin errors++; $display("FAIL reset_abort_ctl got %b exp %b", ctl, IDLE); end
        if (hz.stall_cnt !== 4'd0) begin
            errors++;
            $display("FAIL reset_abort_stall got %0d exp 0", hz.stall_cnt);
        end
        #1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            sb.push_back(IDLE);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (ctl !== e) begin errors++; $display("FAIL reset_after[%0d] got %b exp %b", i, ctl, e); end
        end
        tick();
        checks++;
        if (hz.stall_cnt !== 4'd0) begin
            errors++;
            $display("FAIL reset_residual_stall got %0d exp 0", hz.stall_cnt);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 2; j++) begin
                tick();
                idle();
                if (j == 0) begin
                    hz.ex_mem_read = 1; hz.ex_dest_addr = lu_dst[i];
                    hz.id_rs_addr = lu_rs[i]; hz.id_rt_addr = lu_rt[i]; hz.id_uses_rt = lu_urt[i];
                end
                sb.push_back((j == 0 && lu_stl[i]) ? LU : IDLE);
                @(negedge clk);
                e = sb.pop_front();
                checks++;
                if (ctl !== e) begin errors++; $display("FAIL load_use[%0d.%0d] got %b exp %b", i, j, ctl, e); end
                if (!e[9] && exp_stall < 15) exp_stall++;
            end
        end
        tick();
        checks++;
        if (hz.stall_cnt !== CW'(exp_stall)) begin
            errors++;
            $display("FAIL load_use_stall_cnt got %0d exp %0d", hz.stall_cnt, exp_stall);
        end
    endtask

    task automatic test_multiply();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            tick();
            idle();
            hz.ex_mul_start = (i == 0);
            if (i == 2) begin
                hz.ex_branch_taken = 1; hz.ex_mem_read = 1; hz.ex_dest_addr = 8; hz.id_rs_addr = 8;
            end
            sb.push_back(i == 0 ? MS : (i < 4 ? MB : IDLE));
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (ctl !== e) begin errors++; $display("FAIL multiply[%0d] got %b exp %b", i, ctl, e); end
            if (!e[9] && exp_stall < 15) exp_stall++;
        end
        tick();
        checks += 2;
        if (hz.stall_cnt !== CW'(exp_stall)) begin
            errors++;
            $display("FAIL multiply_stall_cnt got %0d exp %0d", hz.stall_cnt, exp_stall);
        end
        if (hz.flush_cnt !== 4'd0) begin
            errors++;
            $display("FAIL multiply_flush_cnt got %0d exp 0", hz.flush_cnt);
        end
    endtask

    task automatic test_branch();
        do_reset();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) begin
                tick();
                idle();
                if (i == 0) begin
                    hz.ex_branch_taken = 1;
                    if (r == 1) begin
                        hz.ex_mem_read = 1; hz.ex_dest_addr = 8; hz.id_rs_addr = 8;
                    end
                end
                sb.push_back(i == 0 ? BR : (i < 3 ? FL : IDLE));
                @(negedge clk);
                e = sb.pop_front();
                checks++;
                if (ctl !== e) begin errors++; $display("FAIL branch[%0d.%0d] got %b exp %b", r, i, ctl, e); end
                if (!e[9] && exp_stall < 15) exp_stall++;
                if (e == BR && exp_flush < 15) exp_flush++;
            end
        end
        tick();
        checks += 2;
        if (hz.flush_cnt !== CW'(exp_flush)) begin
            errors++;
            $display("FAIL branch_flush_cnt got %0d exp %0d", hz.flush_cnt, exp_flush);
        end
        if (hz.stall_cnt !== CW'(exp_stall)) begin
            errors++;
            $display("FAIL branch_stall_cnt got %0d exp %0d", hz.stall_cnt, exp_stall);
        end
    endtask

    task automatic test_forwarding();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            tick();
            idle();
            hz.ex_rs_addr = f_rs[i]; hz.ex_rt_addr = f_rt[i];
            hz.mem_dest_addr = f_md[i]; hz.mem_reg_write = f_mw[i];
            hz.wb_dest_addr = f_wd[i]; hz.wb_reg_write = f_ww[i];
            sb.push_back({6'b110000, f_a[i], f_b[i]});
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (ctl !== e) begin errors++; $display("FAIL forwarding[%0d] got %b exp %b", i, ctl, e); end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            tick();
            idle();
            hz.ex_mem_read = 1; hz.ex_dest_addr = 8; hz.id_rs_addr = 8;
            sb.push_back(LU);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (ctl !== e) begin errors++; $display("FAIL sat_stall[%0d] got %b exp %b", i, ctl, e); end
            if (!e[9] && exp_stall < 15) exp_stall++;
        end
        tick();
        checks++;
        if (hz.stall_cnt !== CW'(exp_stall)) begin
            errors++;
            $display("FAIL sat_stall_cnt got %0d exp %0d", hz.stall_cnt, exp_stall);
        end
        for (int i = 0; i < 60; i++) begin
            tick();
            idle();
            hz.ex_branch_taken = (i % 3 == 0);
            sb.push_back(i % 3 == 0 ? BR : FL);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (ctl !== e) begin errors++; $display("FAIL sat_flush[%0d] got %b exp %b", i, ctl, e); end
            if (e == BR && exp_flush < 15) exp_flush++;
        end
        tick();
        checks += 2;
        if (hz.flush_cnt !== CW'(exp_flush)) begin
            errors++;
            $display("FAIL sat_flush_cnt got %0d exp %0d", hz.flush_cnt, exp_flush);
        end
        if (hz.stall_cnt !== CW'(exp_stall)) begin
            errors++;
            $display("FAIL sat_stall_hold got %0d exp %0d", hz.stall_cnt, exp_stall);
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_load_use();
        test_multiply();
        test_branch();
        test_forwarding();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
